// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: EX/MEM request, dcache handshake and MEM/WB load-data bundle
interface mem_access_ctrl_if;
  logic        valid_in;
  logic        dmemREN_in;
  logic        dmemWEN_in;
  logic [31:0] addr_in;
  logic [31:0] store_in;
  logic        halt_in;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        mem_stall;
  logic [31:0] dMemLoad;
  logic        mem_done;
  logic        timeout_err;
  modport master (
    input  valid_in, dmemREN_in, dmemWEN_in, addr_in, store_in, halt_in, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, dMemLoad, mem_done, timeout_err
  );
  modport slave (
    output valid_in, dmemREN_in, dmemWEN_in, addr_in, store_in, halt_in, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, dMemLoad, mem_done, timeout_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage dcache access controller with stall, one-cycle done and timeout
module mem_access_ctrl #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hBAD1BAD1
) (
  input logic CLK,
  input logic RST,
  mem_access_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state, state_n;
  logic [9:0]  cnt;
  logic        wr, req, expire, err_q;
  logic [31:0] addr_q, store_q, load_q;
  assign req    = bus.valid_in & (bus.dmemREN_in | bus.dmemWEN_in) & ~bus.halt_in;
  assign expire = cnt == 10'(TIMEOUT - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else     state <= state_n;
  always_comb
    state_n = state == IDLE ? (req ? REQ : IDLE) :
              state == REQ  ? ((bus.dhit | expire) ? DONE : REQ) : IDLE;
  // a write wins when both request flags are set, so only the write flag is kept
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      addr_q  <= '0;
      store_q <= '0;
      load_q  <= '0;
      wr      <= 1'b0;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else if (state == IDLE && req) begin
      addr_q  <= bus.addr_in;
      store_q <= bus.store_in;
      wr      <= bus.dmemWEN_in;
      cnt     <= '0;
    end else if (state == REQ) begin
      cnt <= cnt + 10'd1;
      if (bus.dhit) begin
        if (!wr) load_q <= bus.dmemload;
      end else if (expire) begin
        err_q <= 1'b1;
        if (!wr) load_q <= ERR_DATA;
      end
    end
  // stall is gated by RST so an in-flight stall drops without waiting for an edge
  always_comb begin
    bus.dmemREN     = state == REQ & ~wr;
    bus.dmemWEN     = state == REQ & wr;
    bus.dmemaddr    = addr_q;
    bus.dmemstore   = store_q;
    bus.mem_stall   = ~RST & (state == REQ | (state == IDLE & req));
    bus.mem_done    = state == DONE;
    bus.dMemLoad    = load_q;
    bus.timeout_err = err_q;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Memory-stage data-cache access controller. It is the producer side of the load-data path into the MEM/WB pipeline register. It takes the EX/MEM load/store request, drives the dcache request handshake, and holds the pipeline via mem_stall until the cache returns dhit. It then presents registered load data for exactly one cycle, so the MEM/WB register captures it.

Parameters:
TIMEOUT, 64, max REQ-state cycles without dhit before abandoning the access; legal range 2..1023.
ERR_DATA, 32'hBAD1BAD1, load value returned on a timed-out read.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
valid_in  in  1  EX/MEM slot holds a real instruction
dmemREN_in  in  1  instruction is a load
dmemWEN_in  in  1  instruction is a store
addr_in  in  32  effective address (ALU result)
store_in  in  32  store data
halt_in  in  1  processor halting; block new accesses
dhit  in  1  cache completion strobe
dmemload  in  32  cache read data, valid only while dhit=1
dmemREN  out  1  cache read request
dmemWEN  out  1  cache write request
dmemaddr  out  32  cache address
dmemstore  out  32  cache write data
mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; insert bubble into MEM/WB
dMemLoad  out  32  load data to MEM/WB dMemLoad input
mem_done  out  1  access completes this cycle; MEM/WB captures
timeout_err  out  1  sticky: some access timed out

Behaviour:
- FSM states: IDLE, REQ, DONE. RST forces IDLE immediately regardless of clock.
- Reset values: dmemREN=0, dmemWEN=0, dmemaddr=0, dmemstore=0, dMemLoad=0, mem_done=0, mem_stall=0, timeout_err=0, wait counter=0.
- Request condition: req = valid_in & (dmemREN_in | dmemWEN_in) & ~halt_in.
- When dmemREN_in and dmemWEN_in are both set, the access is a write and the read is dropped.
- IDLE:
  - If req, latch addr_in, store_in and the write flag into internal registers, clear the counter, then go to REQ.
  - mem_stall = req, combinationally, in this cycle.
- REQ:
  - dmemREN / dmemWEN are driven from the latched type; dmemaddr and dmemstore from the latched registers.
  - Outputs stay stable every cycle until exit.
  - mem_stall = 1.
  - Counter increments each REQ cycle.
  - If dhit: capture dmemload into dMemLoad (reads only; writes leave dMemLoad unchanged), go to DONE.
  - Else if counter == TIMEOUT-1: set timeout_err; on a read, load ERR_DATA into dMemLoad; go to DONE.
  - dhit takes priority over timeout in the same cycle.
- DONE:
  - dmemREN = dmemWEN = 0; mem_stall = 0; mem_done = 1.
  - Always go to IDLE next cycle. The new EX/MEM contents are evaluated there, so there is no back-to-back chaining inside DONE.
- Outside REQ, dmemREN and dmemWEN are always 0, so the cache never sees a request in IDLE or DONE.
- Latency: a hit on the first REQ cycle gives a 3-cycle access (accept, REQ, DONE), with mem_stall high for 2 cycles.
- Non-memory instructions and bubbles (valid_in=0) pass with no stall and mem_done=0. dMemLoad holds its last value.
- halt_in:
  - Asserted in IDLE: suppresses acceptance.
  - Asserted during REQ or DONE: the access completes normally.
- timeout_err clears only on RST.
- Input changes on valid_in, addr_in or store_in while in REQ are ignored, because the latched copies are used.
- RST mid-REQ aborts the access: request lines drop asynchronously and no mem_done is issued.

Test Plan:
- Load hit: valid_in=1, dmemREN_in=1, addr_in=0x100; dhit=1 with dmemload=0xDEADBEEF on the first REQ cycle. Required: dmemREN high for exactly 1 cycle at dmemaddr=0x100; mem_stall high for 2 cycles; next cycle mem_done=1 and dMemLoad=0xDEADBEEF.
- Store with 3-cycle miss: dmemWEN_in=1, addr=0x200, store=0x12345678; dhit on the 3rd REQ cycle. Required: dmemWEN, dmemaddr and dmemstore stable for 3 cycles; mem_stall high for 4 cycles; dMemLoad unchanged; mem_done pulses once.
- Timeout: load, dhit never asserted, TIMEOUT=4. Required: exactly 4 REQ cycles; timeout_err=1 and stays 1; dMemLoad=0xBAD1BAD1; mem_done pulses.
- Back-to-back loads: a second load is presented the cycle after DONE. Required: FSM goes IDLE→REQ again; two distinct mem_done pulses; each dMemLoad matches its own dmemload.
- Halt and bubble: halt_in=1 with a load pending in IDLE → no dmemREN, mem_stall=0. valid_in=0 with dmemREN_in=1 → no request.
- Async reset: RST asserted between edges during REQ. Required: dmemREN=0 and mem_stall=0 without waiting for a clock edge; state is IDLE; no mem_done follows.
